// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - control bundle layout shared by the ID/EX pipeline stage
package riscv_pipe_pkg;

  localparam int CTRL_W = 11;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUOP_HI = 8;
  localparam int CTRL_BRANCH   = 9;
  localparam int CTRL_JUMP     = 10;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection for the ID/EX stage
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  flush,
  input  logic                  ext_stall,
  output logic                  load_use_stall
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_in_ex;

  assign w_rs1_hit    = id_uses_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit    = id_uses_rs2 && (id_rs2 == ex_rd);
  assign w_load_in_ex = ex_valid && ex_memread && (ex_rd != '0);

  // An external stall already freezes the whole pipe, so no bubble may be requested under it.
  assign load_use_stall = w_load_in_ex && id_valid && !flush && !ext_stall &&
                          (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - ID/EX register with load-use bubble; HAZARD_PERF_EN builds the bubble counter
module id_ex_pipeline_reg
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic                  id_ex_valid,
  output logic [XLEN-1:0]       id_ex_pc,
  output logic [XLEN-1:0]       id_ex_imm,
  output logic [REG_ADDR_W-1:0] id_ex_rs1,
  output logic [REG_ADDR_W-1:0] id_ex_rs2,
  output logic [REG_ADDR_W-1:0] id_ex_rd,
  output logic [XLEN-1:0]       id_ex_rs1_data,
  output logic [XLEN-1:0]       id_ex_rs2_data,
  output logic [CTRL_W-1:0]     id_ex_ctrl,
  output logic                  load_use_stall,
  output logic [31:0]           stall_count
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_imm;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [CTRL_W-1:0]     r_ctrl;
  logic                  w_load_use_stall;
  logic                  w_bubble;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .ex_valid       (r_valid),
    .ex_memread     (r_ctrl[CTRL_MEMREAD]),
    .ex_rd          (r_rd),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .flush          (flush),
    .ext_stall      (ext_stall),
    .load_use_stall (w_load_use_stall)
  );

  // Flush outranks the external stall; the load-use term is already masked by both.
  assign w_bubble = flush || w_load_use_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_ctrl     <= CTRL_NOP;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_ctrl     <= CTRL_NOP;
    end else if (!ext_stall) begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 32'd0;
    end else if (w_load_use_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'd0;
`endif

  assign id_ex_valid    = r_valid;
  assign id_ex_pc       = r_pc;
  assign id_ex_imm      = r_imm;
  assign id_ex_rs1      = r_rs1;
  assign id_ex_rs2      = r_rs2;
  assign id_ex_rd       = r_rd;
  assign id_ex_rs1_data = r_rs1_data;
  assign id_ex_rs2_data = r_rs2_data;
  assign id_ex_ctrl     = r_ctrl;
  assign load_use_stall = w_load_use_stall;

endmodule
